// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding mp_top: loadable program memory plus a PC that
// issues one word per clock while running, with bubbles on stall and idle.
module instr_fetch_unit #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int IW     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [IW-1:0]     wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              stall,
    output logic [IW-1:0]     instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   issued_cnt,
    output logic [ADDR_W:0]   invalid_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    state_t            state;
    logic [IW-1:0]     mem [DEPTH];
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_clamped;
    logic              last_word;
    logic [IW-1:0]     cur_word;

    // Opcodes mp_top executes; everything else (including the all-zero bubble) is invalid.
    function automatic logic opcode_invalid(input logic [5:0] op);
        case (op)
            6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8,
            6'd10, 6'd12, 6'd13, 6'd15: return 1'b0;
            default:                    return 1'b1;
        endcase
    endfunction

    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_word   = ({1'b0, pc} == (len - CNT_ONE));
    assign cur_word    = mem[pc];

    // Program memory carries no reset; writes only land while the fetcher is idle.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            issued_cnt  <= '0;
            invalid_cnt <= '0;
            len         <= '0;
        end else begin
            instruction <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc          <= '0;
                        issued_cnt  <= '0;
                        invalid_cnt <= '0;
                        len         <= len_clamped;
                        if (len_clamped == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        instruction <= cur_word;
                        instr_valid <= 1'b1;
                        pc          <= pc + PC_ONE;
                        issued_cnt  <= issued_cnt + CNT_ONE;
                        if (opcode_invalid(cur_word[5:0])) begin
                            invalid_cnt <= invalid_cnt + CNT_ONE;
                        end
                        if (last_word) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    pc    <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
